// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM controller (mt48lc2m32b2 geometry).
package sdram_pkg;

  localparam int SDR_ADDR_W = 11;
  localparam int SDR_BA_W   = 2;
  localparam int SDR_COL_W  = 8;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_REF,
    ST_WR,
    ST_RD
  } state_t;

  // {csn, rasn, casn, wen}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic auto-refresh demand: free-running interval counter, owed flag and sticky overrun flag.
module sdram_ref_timer #(
  parameter int REF_INTERVAL = 1560
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic ref_start,
  output logic ref_pending,
  output logic ref_miss
);

  localparam int CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [CW-1:0] count;
  logic          wrap;

  assign wrap = enable && (count == CW'(REF_INTERVAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      ref_pending <= 1'b0;
      ref_miss    <= 1'b0;
    end else begin
      if (!enable || wrap) count <= '0;
      else                 count <= count + CW'(1);

      // A new demand wins over the grant that would clear the old one.
      if (wrap)           ref_pending <= 1'b1;
      else if (ref_start) ref_pending <= 1'b0;

      if (wrap && ref_pending) ref_miss <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Top-level SDRAM sequencer: waits for init, arbitrates refresh/write/read and drives registered pins.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = 1560,
  parameter int ADDR_W       = SDR_ADDR_W,
  parameter int BA_W         = SDR_BA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [3:0]        init_cmd,
  input  logic [3:0]        ref_cmd,
  input  logic [3:0]        wr_cmd,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ref_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [BA_W-1:0]   ref_ba,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              ref_done,
  input  logic              wr_done,
  input  logic              rd_done,
  output logic              ref_start,
  output logic              wr_start,
  output logic              rd_start,
  output logic              ref_pending,
  output logic              ref_miss,
  output logic              sdr_csn,
  output logic              sdr_rasn,
  output logic              sdr_casn,
  output logic              sdr_wen,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [BA_W-1:0]   sdr_ba
);

  state_t state_q, state_d;
  logic   ref_go, wr_go, rd_go;
  logic   last_rd;

  logic [3:0]        cmd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [BA_W-1:0]   ba_d;

  sdram_ref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref_timer (
    .clk         (clk),
    .rst         (rst),
    .enable      (state_q != ST_INIT),
    .ref_start   (ref_go),
    .ref_pending (ref_pending),
    .ref_miss    (ref_miss)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      ref_start <= 1'b0;
      wr_start  <= 1'b0;
      rd_start  <= 1'b0;
      last_rd   <= 1'b1;
    end else begin
      state_q   <= state_d;
      ref_start <= ref_go;
      wr_start  <= wr_go;
      rd_start  <= rd_go;
      if (wr_go)      last_rd <= 1'b0;
      else if (rd_go) last_rd <= 1'b1;
    end
  end

  // Grants only leave IDLE, so every operation is bracketed by an IDLE cycle.
  always_comb begin
    state_d = state_q;
    ref_go  = 1'b0;
    wr_go   = 1'b0;
    rd_go   = 1'b0;
    unique case (state_q)
      ST_INIT: if (init_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (ref_pending) begin
          state_d = ST_REF;
          ref_go  = 1'b1;
        end else if (wr_req && (!rd_req || last_rd)) begin
          state_d = ST_WR;
          wr_go   = 1'b1;
        end else if (rd_req) begin
          state_d = ST_RD;
          rd_go   = 1'b1;
        end
      end
      ST_REF:  if (ref_done) state_d = ST_IDLE;
      ST_WR:   if (wr_done)  state_d = ST_IDLE;
      ST_RD:   if (rd_done)  state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    unique case (state_q)
      ST_INIT: begin cmd_d = init_cmd; addr_d = init_addr; ba_d = init_ba; end
      ST_REF:  begin cmd_d = ref_cmd;  addr_d = ref_addr;  ba_d = ref_ba;  end
      ST_WR:   begin cmd_d = wr_cmd;   addr_d = wr_addr;   ba_d = wr_ba;   end
      ST_RD:   begin cmd_d = rd_cmd;   addr_d = rd_addr;   ba_d = rd_ba;   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {sdr_csn, sdr_rasn, sdr_casn, sdr_wen} <= CMD_DESEL;
      sdr_addr <= '0;
      sdr_ba   <= '0;
    end else begin
      {sdr_csn, sdr_rasn, sdr_casn, sdr_wen} <= cmd_d;
      sdr_addr <= addr_d;
      sdr_ba   <= ba_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: grant order scoreboard, refresh timing, pin mux and reset behaviour.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int RI = 64;
  localparam int K_REF = 1, K_WR = 2, K_RD = 3;

  logic        clk = 1'b0, rst = 1'b1, init_done = 1'b0;
  logic [3:0]  init_cmd, ref_cmd, wr_cmd, rd_cmd;
  logic [10:0] init_addr, ref_addr, wr_addr, rd_addr, sdr_addr;
  logic [1:0]  init_ba, ref_ba, wr_ba, rd_ba, sdr_ba;
  logic        wr_req = 0, rd_req = 0, ref_done = 0, wr_done = 0, rd_done = 0;
  logic        ref_start, wr_start, rd_start, ref_pending, ref_miss;
  logic        sdr_csn, sdr_rasn, sdr_casn, sdr_wen;

  int ncmp = 0, nfail = 0, cyc = 0;
  int exp_q[$];

  sdram_arbiter #(.REF_INTERVAL(RI), .ADDR_W(11), .BA_W(2)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .init_cmd(init_cmd), .ref_cmd(ref_cmd), .wr_cmd(wr_cmd), .rd_cmd(rd_cmd),
    .init_addr(init_addr), .ref_addr(ref_addr), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .init_ba(init_ba), .ref_ba(ref_ba), .wr_ba(wr_ba), .rd_ba(rd_ba),
    .wr_req(wr_req), .rd_req(rd_req),
    .ref_done(ref_done), .wr_done(wr_done), .rd_done(rd_done),
    .ref_start(ref_start), .wr_start(wr_start), .rd_start(rd_start),
    .ref_pending(ref_pending), .ref_miss(ref_miss),
    .sdr_csn(sdr_csn), .sdr_rasn(sdr_rasn), .sdr_casn(sdr_casn), .sdr_wen(sdr_wen),
    .sdr_addr(sdr_addr), .sdr_ba(sdr_ba)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] pins();
    return {sdr_csn, sdr_rasn, sdr_casn, sdr_wen, sdr_addr, sdr_ba};
  endfunction

  function automatic logic [16:0] src(input int k);
    case (k)
      K_REF:   return {ref_cmd, ref_addr, ref_ba};
      K_WR:    return {wr_cmd, wr_addr, wr_ba};
      K_RD:    return {rd_cmd, rd_addr, rd_ba};
      default: return {init_cmd, init_addr, init_ba};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Waits for any start pulse; kind 0 means the budget ran out.
  task automatic wait_start(input int budget, output int kind);
    kind = 0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (ref_start || wr_start || rd_start) begin
        chk("start_onehot", 32'(ref_start) + 32'(wr_start) + 32'(rd_start), 1);
        kind = ref_start ? K_REF : (wr_start ? K_WR : K_RD);
        return;
      end
    end
    chk("start_timeout", 0, 1);
  endtask

  task automatic check_grant(input int kind);
    if (exp_q.size() == 0) chk("grant_unexpected", kind, 0);
    else chk("grant_order", kind, exp_q.pop_front());
  endtask

  // Acts as the granted sub-FSM: done returned 4 cycles after start.
  task automatic serve(input int kind);
    step();
    chk("start_width", {ref_start, wr_start, rd_start}, 0);
    chk("pins_src", pins(), src(kind));
    step();
    step();
    case (kind)
      K_REF:   ref_done = 1;
      K_WR:    wr_done = 1;
      default: rd_done = 1;
    endcase
    step();
    {ref_done, wr_done, rd_done} = '0;
  endtask

  initial begin
    int k, t0, t1, nst;
    init_cmd = CMD_MRS; init_addr = 11'h155; init_ba = 2'd1;
    ref_cmd  = CMD_REF; ref_addr  = 11'h400; ref_ba  = 2'd2;
    wr_cmd   = CMD_WR;  wr_addr   = 11'h123; wr_ba   = 2'd3;
    rd_cmd   = CMD_RD;  rd_addr   = 11'h321; rd_ba   = 2'd1;

    // Reset values
    repeat (3) step();
    chk("rst_pins", pins(), {CMD_DESEL, 11'h0, 2'h0});
    chk("rst_starts", {ref_start, wr_start, rd_start}, 0);
    chk("rst_flags", {ref_pending, ref_miss}, 0);

    // INIT mirrors init source with one cycle of latency
    rst = 0;
    step();
    chk("init_mirror", pins(), {CMD_MRS, 11'h155, 2'd1});
    init_addr = 11'h0F0;
    step();
    chk("init_latency", sdr_addr, 11'h0F0);
    repeat (18) step();
    init_done = 1;
    step();
    chk("init_last", pins(), {CMD_MRS, 11'h0F0, 2'd1});
    step();
    chk("idle_nop", pins(), {CMD_NOP, 11'h0, 2'h0});

    // Periodic refresh with no traffic
    exp_q.push_back(K_REF); exp_q.push_back(K_REF); exp_q.push_back(K_REF);
    wait_start(80, k); check_grant(k); t0 = cyc; serve(k);
    wait_start(80, k); check_grant(k); t1 = cyc; serve(k);
    chk("ref_period1", t1 - t0, RI);
    wait_start(80, k); check_grant(k); t0 = cyc; serve(k);
    chk("ref_period2", t0 - t1, RI);
    chk("no_miss", ref_miss, 0);

    // Round-robin with both requests held
    exp_q.push_back(K_WR); exp_q.push_back(K_RD);
    exp_q.push_back(K_WR); exp_q.push_back(K_RD);
    wr_req = 1; rd_req = 1;
    for (int i = 0; i < 4; i++) begin
      wait_start(20, k);
      if (i == 3) begin wr_req = 0; rd_req = 0; end
      check_grant(k);
      serve(k);
    end

    // Refresh demand arriving during a write
    exp_q.push_back(K_WR);
    wr_req = 1;
    wait_start(10, k); check_grant(k);
    step();
    chk("wr_pins", pins(), src(K_WR));
    for (int n = 0; n < 70 && !ref_pending; n++) step();
    chk("pend_in_wr", ref_pending, 1);
    chk("wr_continues", pins(), src(K_WR));
    chk("no_ref_in_wr", ref_start, 0);
    exp_q.push_back(K_REF);
    wr_done = 1; step(); wr_done = 0;
    wait_start(5, k); check_grant(k); serve(k);
    exp_q.push_back(K_WR);
    wait_start(5, k); wr_req = 0; check_grant(k); serve(k);

    // Refresh held past two wraps
    exp_q.push_back(K_REF);
    wait_start(80, k); check_grant(k);
    for (int n = 0; n < 70 && !ref_pending; n++) step();
    chk("pend_wrap1", ref_pending, 1);
    chk("miss_wrap1", ref_miss, 0);
    t0 = cyc;
    for (int n = 0; n < 70 && !ref_miss; n++) step();
    chk("miss_wrap2", ref_miss, 1);
    chk("miss_interval", cyc - t0, RI);
    repeat (3) step();
    chk("miss_sticky", ref_miss, 1);
    exp_q.push_back(K_REF);
    ref_done = 1; step(); ref_done = 0;
    wait_start(5, k); check_grant(k); serve(k);
    chk("miss_sticky2", ref_miss, 1);

    // Reset in the middle of a read
    exp_q.push_back(K_RD);
    rd_req = 1;
    wait_start(10, k); check_grant(k);
    step();
    #2 rst = 1; init_done = 0;
    #1;
    chk("rst_mid_pins", pins(), {CMD_DESEL, 11'h0, 2'h0});
    chk("rst_mid_flags", {rd_start, ref_pending, ref_miss}, 0);
    step();
    rst = 0;
    nst = 0;
    for (int n = 0; n < 10; n++) begin
      rd_done = (n == 2);
      step();
      if (ref_start || wr_start || rd_start) nst++;
    end
    rd_done = 0; rd_req = 0;
    chk("post_rst_starts", nst, 0);
    chk("post_rst_init", pins(), src(0));
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
